// File: rtl/i2c_frame_timer_if.sv
// i2c_frame_timer_if
//   Bundles the pulse inputs and the frame-status outputs of the I2C slave
//   receive-path frame timer.
//
//   master : the edge / start-stop detectors side (drives the pulses,
//            observes the frame status)
//   slave  : the frame timer itself
//
//   rising_edge_found   1      1-cycle pulse on an SCL rising edge
//   falling_edge_found  1      1-cycle pulse on an SCL falling edge
//   start_found         1      1-cycle pulse on START or repeated START
//   stop_found          1      1-cycle pulse on STOP
//   bit_index           BIT_W  data bits sampled in the current word
//   word_received       1      word complete, waiting for the ACK slot
//   ack_prep            1      ACK slot being prepared
//   check_ack           1      ACK slot being sampled
//   ack_done            1      1-cycle end-of-ACK strobe
//   word_count          WC_W   words completed since the last START
//   timeout             1      1-cycle abort pulse on a stalled bus
interface i2c_frame_timer_if #(
  parameter int BIT_W = 4,
  parameter int WC_W  = 8
);
  logic             rising_edge_found;
  logic             falling_edge_found;
  logic             start_found;
  logic             stop_found;
  logic [BIT_W-1:0] bit_index;
  logic             word_received;
  logic             ack_prep;
  logic             check_ack;
  logic             ack_done;
  logic [WC_W-1:0]  word_count;
  logic             timeout;

  modport master (
    output rising_edge_found,
    output falling_edge_found,
    output start_found,
    output stop_found,
    input  bit_index,
    input  word_received,
    input  ack_prep,
    input  check_ack,
    input  ack_done,
    input  word_count,
    input  timeout
  );

  modport slave (
    input  rising_edge_found,
    input  falling_edge_found,
    input  start_found,
    input  stop_found,
    output bit_index,
    output word_received,
    output ack_prep,
    output check_ack,
    output ack_done,
    output word_count,
    output timeout
  );
endinterface

// File: rtl/i2c_frame_timer.sv
// i2c_frame_timer
//   SCL-edge sequencer for the I2C slave receive path. Counts WORD_BITS data
//   bits per word on SCL rising edges, then walks the ACK slot (prep, check,
//   done), counts the words received since the last START and aborts the
//   frame when the bus stalls for TIMEOUT_CYCLES clocks.
//
//   clk    system clock
//   n_rst  asynchronous reset, active-low
//   bus    i2c_frame_timer_if.slave: edge/start/stop pulses in,
//          bit_index / word / ACK / word_count / timeout status out
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | no frame in progress, waiting for START
//   SHIFT     | sampling data bits on SCL rising edges
//   WORD_RCVD | last data bit sampled, waiting for SCL fall
//   ACK_PREP  | ACK bit being set up, waiting for SCL rise
//   ACK_CHECK | ACK bit on the bus, waiting for SCL fall
//   ACK_DONE  | one-cycle end of ACK slot, back to SHIFT
module i2c_frame_timer #(
  parameter int WORD_BITS      = 8,
  parameter int ACK_EN         = 1,
  parameter int WC_W           = 8,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int BIT_W          = $clog2(WORD_BITS + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  i2c_frame_timer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WORD_RCVD,
    ACK_PREP,
    ACK_CHECK,
    ACK_DONE
  } state_t;

  // The quiet counter only ever needs to reach TIMEOUT_CYCLES-1: the cycle
  // that would make it TIMEOUT_CYCLES is the firing cycle itself.
  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
  localparam bit               TMO_ON   = (TIMEOUT_CYCLES > 0);
  localparam bit               ACK_ON   = (ACK_EN != 0);

  state_t           state;
  state_t           state_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_nxt;
  logic [WC_W-1:0]  word_cnt;
  logic [WC_W-1:0]  word_cnt_nxt;
  logic [TMO_W-1:0] quiet_cnt;
  logic [TMO_W-1:0] quiet_cnt_nxt;
  logic             any_pulse;
  logic             tmo_fire;

  logic             word_rcvd_q;
  logic             ack_prep_q;
  logic             check_ack_q;
  logic             ack_done_q;
  logic             timeout_q;

  // Next-state logic. STOP beats START, START beats the stall abort, and the
  // abort beats the per-state edge rules. Each state listens only to the
  // edge it is waiting for, so a simultaneous opposite edge is dropped.
  always_comb begin
    any_pulse = bus.rising_edge_found | bus.falling_edge_found |
                bus.start_found | bus.stop_found;
    tmo_fire  = TMO_ON && (state != IDLE) && !any_pulse && (quiet_cnt == TMO_LAST);

    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    word_cnt_nxt = word_cnt;

    if (bus.stop_found) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end else if (bus.start_found) begin
      state_nxt    = SHIFT;
      bit_cnt_nxt  = '0;
      word_cnt_nxt = '0;
    end else if (tmo_fire) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
        end
        SHIFT: begin
          if (bus.rising_edge_found) begin
            if (bit_cnt == BIT_LAST) begin
              state_nxt    = WORD_RCVD;
              bit_cnt_nxt  = '0;
              word_cnt_nxt = word_cnt + WC_W'(1);
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
            end
          end
        end
        WORD_RCVD: begin
          if (bus.falling_edge_found) begin
            state_nxt = ACK_ON ? ACK_PREP : SHIFT;
          end
        end
        ACK_PREP: begin
          if (bus.rising_edge_found) begin
            state_nxt = ACK_CHECK;
          end
        end
        ACK_CHECK: begin
          if (bus.falling_edge_found) begin
            state_nxt = ACK_DONE;
          end
        end
        ACK_DONE: begin
          state_nxt = SHIFT;
        end
        default: begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end

    // Stall counter: parked at zero in IDLE, restarted by any bus activity
    // or by any state change (including the pulse-less ACK_DONE exit).
    if (!TMO_ON || (state == IDLE) || any_pulse || (state_nxt != state)) begin
      quiet_cnt_nxt = '0;
    end else begin
      quiet_cnt_nxt = quiet_cnt + TMO_W'(1);
    end
  end

  // Status outputs are registered straight from the next state so they
  // coincide with the state register (Moore, one cycle after the pulse).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      quiet_cnt   <= '0;
      word_rcvd_q <= 1'b0;
      ack_prep_q  <= 1'b0;
      check_ack_q <= 1'b0;
      ack_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      word_cnt    <= word_cnt_nxt;
      quiet_cnt   <= quiet_cnt_nxt;
      word_rcvd_q <= (state_nxt == WORD_RCVD);
      ack_prep_q  <= ACK_ON && (state_nxt == ACK_PREP);
      check_ack_q <= ACK_ON && (state_nxt == ACK_CHECK);
      ack_done_q  <= ACK_ON && (state_nxt == ACK_DONE);
      timeout_q   <= tmo_fire;
    end
  end

  assign bus.bit_index     = bit_cnt;
  assign bus.word_received = word_rcvd_q;
  assign bus.ack_prep      = ack_prep_q;
  assign bus.check_ack     = check_ack_q;
  assign bus.ack_done      = ack_done_q;
  assign bus.word_count    = word_cnt;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_i2c_frame_timer.sv
// tb_i2c_frame_timer
//   Drives one shared pulse stream into three frame-timer configurations
//   (defaults; TIMEOUT_CYCLES=16; ACK_EN=0 with WORD_BITS=9) and checks them
//   against directed expectations and a per-configuration reference model.
module tb_i2c_frame_timer;

  logic clk = 1'b0;
  logic n_rst;
  logic rise, fall, start, stop;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_frame_timer_if #(.BIT_W(4), .WC_W(8)) if_def ();
  i2c_frame_timer_if #(.BIT_W(4), .WC_W(8)) if_tmo ();
  i2c_frame_timer_if #(.BIT_W(4), .WC_W(8)) if_nak ();

  assign if_def.rising_edge_found  = rise;
  assign if_def.falling_edge_found = fall;
  assign if_def.start_found        = start;
  assign if_def.stop_found         = stop;
  assign if_tmo.rising_edge_found  = rise;
  assign if_tmo.falling_edge_found = fall;
  assign if_tmo.start_found        = start;
  assign if_tmo.stop_found         = stop;
  assign if_nak.rising_edge_found  = rise;
  assign if_nak.falling_edge_found = fall;
  assign if_nak.start_found        = start;
  assign if_nak.stop_found         = stop;

  i2c_frame_timer #(.WORD_BITS(8), .ACK_EN(1), .WC_W(8), .TIMEOUT_CYCLES(0))
    u_def (.clk(clk), .n_rst(n_rst), .bus(if_def));
  i2c_frame_timer #(.WORD_BITS(8), .ACK_EN(1), .WC_W(8), .TIMEOUT_CYCLES(16))
    u_tmo (.clk(clk), .n_rst(n_rst), .bus(if_tmo));
  i2c_frame_timer #(.WORD_BITS(9), .ACK_EN(0), .WC_W(8), .TIMEOUT_CYCLES(0))
    u_nak (.clk(clk), .n_rst(n_rst), .bus(if_nak));

  // {bit_index, word_received, ack_prep, check_ack, ack_done, timeout, word_count}
  logic [16:0] obs_def, obs_tmo, obs_nak;
  assign obs_def = {if_def.bit_index, if_def.word_received, if_def.ack_prep, if_def.check_ack,
                    if_def.ack_done, if_def.timeout, if_def.word_count};
  assign obs_tmo = {if_tmo.bit_index, if_tmo.word_received, if_tmo.ack_prep, if_tmo.check_ack,
                    if_tmo.ack_done, if_tmo.timeout, if_tmo.word_count};
  assign obs_nak = {if_nak.bit_index, if_nak.word_received, if_nak.ack_prep, if_nak.check_ack,
                    if_nak.ack_done, if_nak.timeout, if_nak.word_count};

  // Reference model: frame phase, bits taken in the current word, words
  // since START and consecutive quiet cycles.
  localparam int P_IDLE  = 0;
  localparam int P_BITS  = 1;
  localparam int P_WORD  = 2;
  localparam int P_PREP  = 3;
  localparam int P_CHECK = 4;
  localparam int P_DONE  = 5;

  typedef struct {
    int phase;
    int bits;
    int words;
    int quiet;
    bit aborted;
  } mdl_t;

  mdl_t m_def, m_tmo, m_nak;

  function automatic mdl_t mdl_step(mdl_t m, int word_bits, bit ack_en, int tmo_cycles,
                                    bit r, bit f, bit s, bit p);
    mdl_t n;
    bit   busy;
    n = m;
    busy = r | f | s | p;
    n.aborted = 1'b0;
    if (p) begin
      n.phase = P_IDLE;
      n.bits  = 0;
    end else if (s) begin
      n.phase = P_BITS;
      n.bits  = 0;
      n.words = 0;
    end else if (tmo_cycles > 0 && m.phase != P_IDLE && !busy && m.quiet + 1 == tmo_cycles) begin
      n.aborted = 1'b1;
      n.phase   = P_IDLE;
      n.bits    = 0;
    end else begin
      case (m.phase)
        P_BITS: if (r) begin
          n.bits = m.bits + 1;
          if (n.bits == word_bits) begin
            n.bits  = 0;
            n.words = (m.words + 1) % 256;
            n.phase = P_WORD;
          end
        end
        P_WORD:  if (f) n.phase = ack_en ? P_PREP : P_BITS;
        P_PREP:  if (r) n.phase = P_CHECK;
        P_CHECK: if (f) n.phase = P_DONE;
        P_DONE:  n.phase = P_BITS;
        default: ;
      endcase
    end
    n.quiet = (m.phase == P_IDLE || busy || n.phase != m.phase) ? 0 : m.quiet + 1;
    return n;
  endfunction

  function automatic logic [16:0] mdl_out(mdl_t m, bit ack_en);
    return {4'(m.bits), m.phase == P_WORD, ack_en && m.phase == P_PREP,
            ack_en && m.phase == P_CHECK, ack_en && m.phase == P_DONE, m.aborted, 8'(m.words)};
  endfunction

  task automatic mdl_reset();
    m_def = '{P_IDLE, 0, 0, 0, 1'b0};
    m_tmo = '{P_IDLE, 0, 0, 0, 1'b0};
    m_nak = '{P_IDLE, 0, 0, 0, 1'b0};
  endtask

  // Apply one cycle of pulses; returns 1 time unit after the sampling edge.
  task automatic tick(input bit r, input bit f, input bit s, input bit p);
    rise = r; fall = f; start = s; stop = p;
    @(posedge clk);
    m_def = mdl_step(m_def, 8, 1'b1, 0,  r, f, s, p);
    m_tmo = mdl_step(m_tmo, 8, 1'b1, 16, r, f, s, p);
    m_nak = mdl_step(m_nak, 9, 1'b0, 0,  r, f, s, p);
    #1;
    rise = 1'b0; fall = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    rise = 1'b0; fall = 1'b0; start = 1'b0; stop = 1'b0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (obs_def !== 17'h0) begin n_err++; $display("FAIL reset_def got %h want %h", obs_def, 17'h0); end
    n_vec++; if (obs_tmo !== 17'h0) begin n_err++; $display("FAIL reset_tmo got %h want %h", obs_tmo, 17'h0); end
    n_vec++; if (obs_nak !== 17'h0) begin n_err++; $display("FAIL reset_nak got %h want %h", obs_nak, 17'h0); end
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word();
    tick(0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      tick(1, 0, 0, 0);
      if (k < 8) begin
        n_vec++;
        if (if_def.bit_index !== 4'(k) || if_def.word_received !== 1'b0) begin
          n_err++; $display("FAIL word_bit%0d got idx=%0d wr=%b want idx=%0d wr=0", k, if_def.bit_index, if_def.word_received, k);
        end
        repeat (3) tick(0, 0, 0, 0);
      end
    end
    n_vec++;
    if (if_def.word_received !== 1'b1 || if_def.bit_index !== 4'd0 || if_def.word_count !== 8'd1) begin
      n_err++; $display("FAIL word_done got wr=%b idx=%0d wc=%0d want wr=1 idx=0 wc=1", if_def.word_received, if_def.bit_index, if_def.word_count);
    end
  endtask

  task automatic test_ack();
    tick(0, 1, 0, 0);
    n_vec++; if (if_def.ack_prep !== 1'b1 || if_def.word_received !== 1'b0) begin n_err++; $display("FAIL ack_prep got %b want 1", if_def.ack_prep); end
    tick(0, 0, 0, 0);
    n_vec++; if (if_def.ack_prep !== 1'b1) begin n_err++; $display("FAIL ack_prep_hold got %b want 1", if_def.ack_prep); end
    tick(1, 0, 0, 0);
    n_vec++; if (if_def.check_ack !== 1'b1 || if_def.ack_prep !== 1'b0) begin n_err++; $display("FAIL check_ack got %b want 1", if_def.check_ack); end
    tick(0, 1, 0, 0);
    n_vec++; if (if_def.ack_done !== 1'b1 || if_def.check_ack !== 1'b0) begin n_err++; $display("FAIL ack_done got %b want 1", if_def.ack_done); end
    tick(0, 0, 0, 0);
    n_vec++; if (obs_def !== 17'h00001) begin n_err++; $display("FAIL ack_exit got %h want %h", obs_def, 17'h00001); end
    tick(1, 0, 0, 0);
    n_vec++; if (if_def.bit_index !== 4'd1) begin n_err++; $display("FAIL ack_to_shift got idx=%0d want 1", if_def.bit_index); end
  endtask

  task automatic test_stop();
    bit seen_wr;
    seen_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 0, 0);
      seen_wr |= if_def.word_received;
      tick(0, 0, 0, 0);
      seen_wr |= if_def.word_received;
    end
    n_vec++; if (if_def.bit_index !== 4'd5) begin n_err++; $display("FAIL stop_pre got idx=%0d want 5", if_def.bit_index); end
    tick(0, 0, 0, 1);
    seen_wr |= if_def.word_received;
    n_vec++;
    if (if_def.bit_index !== 4'd0 || if_def.word_count !== 8'd1 || seen_wr !== 1'b0) begin
      n_err++; $display("FAIL stop got idx=%0d wc=%0d wr_seen=%b want idx=0 wc=1 wr_seen=0", if_def.bit_index, if_def.word_count, seen_wr);
    end
    tick(1, 0, 0, 0);
    n_vec++; if (if_def.bit_index !== 4'd0) begin n_err++; $display("FAIL idle_ignores_rise got idx=%0d want 0", if_def.bit_index); end
  endtask

  task automatic test_restart();
    tick(0, 0, 1, 0);
    for (int w = 0; w < 2; w++) begin
      repeat (8) tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
    end
    n_vec++; if (if_def.word_count !== 8'd2) begin n_err++; $display("FAIL restart_wc2 got %0d want 2", if_def.word_count); end
    repeat (3) tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    n_vec++;
    if (if_def.bit_index !== 4'd0 || if_def.word_count !== 8'd0) begin
      n_err++; $display("FAIL restart got idx=%0d wc=%0d want idx=0 wc=0", if_def.bit_index, if_def.word_count);
    end
    tick(1, 0, 0, 0);
    n_vec++; if (if_def.bit_index !== 4'd1) begin n_err++; $display("FAIL restart_shift got idx=%0d want 1", if_def.bit_index); end
    tick(0, 0, 1, 1);
    tick(1, 0, 0, 0);
    n_vec++; if (obs_def !== 17'h0) begin n_err++; $display("FAIL start_stop_same got %h want %h", obs_def, 17'h0); end
  endtask

  task automatic test_timeout();
    tick(0, 0, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 0, 0);
      n_vec++;
      if (if_tmo.timeout !== (i == 16)) begin n_err++; $display("FAIL tmo_quiet%0d got %b want %b", i, if_tmo.timeout, i == 16); end
    end
    tick(1, 0, 0, 0);
    n_vec++;
    if (if_tmo.timeout !== 1'b0 || if_tmo.bit_index !== 4'd0) begin
      n_err++; $display("FAIL tmo_after got to=%b idx=%0d want to=0 idx=0", if_tmo.timeout, if_tmo.bit_index);
    end
    tick(0, 0, 1, 0);
    repeat (14) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 0, 0);
      n_vec++;
      if (if_tmo.timeout !== (i == 16)) begin n_err++; $display("FAIL tmo_restart%0d got %b want %b", i, if_tmo.timeout, i == 16); end
    end
    tick(0, 0, 1, 0);
    repeat (15) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    n_vec++; if (if_tmo.timeout !== 1'b0) begin n_err++; $display("FAIL tmo_stop_wins got %b want 0", if_tmo.timeout); end
    n_vec++; if (if_def.timeout !== 1'b0) begin n_err++; $display("FAIL tmo_disabled got %b want 0", if_def.timeout); end
  endtask

  task automatic test_noack();
    tick(0, 0, 1, 0);
    for (int w = 0; w < 256; w++) begin
      repeat (9) tick(1, 0, 0, 0);
      if (w == 0) begin
        n_vec++;
        if (if_nak.word_received !== 1'b1 || if_nak.bit_index !== 4'd0 || if_nak.word_count !== 8'd1) begin
          n_err++; $display("FAIL nak_word got wr=%b idx=%0d wc=%0d want wr=1 idx=0 wc=1", if_nak.word_received, if_nak.bit_index, if_nak.word_count);
        end
      end
      tick(0, 1, 0, 0);
      n_vec++;
      if ({if_nak.word_received, if_nak.ack_prep, if_nak.check_ack, if_nak.ack_done} !== 4'b0000) begin
        n_err++; $display("FAIL nak_fall%0d got wr/ap/ca/ad=%b%b%b%b want 0000", w, if_nak.word_received, if_nak.ack_prep, if_nak.check_ack, if_nak.ack_done);
      end
      if (w == 254) begin
        n_vec++; if (if_nak.word_count !== 8'd255) begin n_err++; $display("FAIL nak_wc255 got %0d want 255", if_nak.word_count); end
      end
    end
    n_vec++; if (if_nak.word_count !== 8'd0) begin n_err++; $display("FAIL nak_wrap got %0d want 0", if_nak.word_count); end
    n_vec++; if (obs_nak !== mdl_out(m_nak, 1'b0)) begin n_err++; $display("FAIL nak_model got %h want %h", obs_nak, mdl_out(m_nak, 1'b0)); end
  endtask

  task automatic test_async_reset();
    tick(0, 0, 1, 0);
    repeat (3) tick(1, 0, 0, 0);
    #2;
    n_rst = 1'b0;
    #1;
    n_vec++; if (obs_def !== 17'h0) begin n_err++; $display("FAIL areset_def got %h want %h", obs_def, 17'h0); end
    n_vec++; if (obs_tmo !== 17'h0) begin n_err++; $display("FAIL areset_tmo got %h want %h", obs_tmo, 17'h0); end
    n_vec++; if (obs_nak !== 17'h0) begin n_err++; $display("FAIL areset_nak got %h want %h", obs_nak, 17'h0); end
    mdl_reset();
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int gap;
    bit r, f, s, p;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0) gap = $urandom_range(1, 20);
      else gap = 0;
      for (int g = 0; g <= gap; g++) begin
        if (g < gap) begin
          r = 1'b0; f = 1'b0; s = 1'b0; p = 1'b0;
        end else begin
          r = ($urandom_range(0, 99) < 40);
          f = ($urandom_range(0, 99) < 40);
          s = ($urandom_range(0, 99) < 3);
          p = ($urandom_range(0, 99) < 3);
        end
        tick(r, f, s, p);
        n_vec++; if (obs_def !== mdl_out(m_def, 1'b1)) begin n_err++; $display("FAIL rand_def@%0d got %h want %h", i, obs_def, mdl_out(m_def, 1'b1)); end
        n_vec++; if (obs_tmo !== mdl_out(m_tmo, 1'b1)) begin n_err++; $display("FAIL rand_tmo@%0d got %h want %h", i, obs_tmo, mdl_out(m_tmo, 1'b1)); end
        n_vec++; if (obs_nak !== mdl_out(m_nak, 1'b0)) begin n_err++; $display("FAIL rand_nak@%0d got %h want %h", i, obs_nak, mdl_out(m_nak, 1'b0)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_ack();
    test_stop();
    test_restart();
    test_timeout();
    test_noack();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
